seq_array_divider: RTL

- Iterative restoring divider: the inverse operation of the team's combinational array multiplier.
- Takes an unsigned DIVIDEND_W-bit dividend and DIVISOR_W-bit divisor; returns quotient and remainder.
- One quotient bit per clock; valid/ready handshake on both sides.
- Sits beside the multiplier in the arithmetic datapath; verification uses it for P/B = A round-trip checks.

---
 rtl/seq_array_divider_if.sv | 25 ++
 rtl/seq_array_divider.sv | 102 ++++++++++
 2 files changed

// File: rtl/seq_array_divider_if.sv
// Handshake bus for the sequential restoring divider: operand request and result response.
interface seq_array_divider_if #(
   parameter int DIVIDEND_W = 8,
   parameter int DIVISOR_W  = 4
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DIVIDEND_W-1:0] dividend;
   logic [DIVISOR_W-1:0]  divisor;
   logic                  out_valid;
   logic                  out_ready;
   logic [DIVIDEND_W-1:0] quotient;
   logic [DIVISOR_W-1:0]  remainder;
   logic                  div_by_zero;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_array_divider.sv
// Iterative restoring divider: one quotient bit per clock, valid/ready on both sides.
module seq_array_divider #(
   parameter int DIVIDEND_W = 8,
   parameter int DIVISOR_W  = 4
) (
   input  logic                clk,
   input  logic                rst,
   seq_array_divider_if.slave  bus
);
   localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIVIDEND_W - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                r_state;
   logic [DIVIDEND_W-1:0] r_shift;
   logic [DIVISOR_W-1:0]  r_divisor;
   logic [DIVISOR_W:0]    r_pr;
   logic [CNT_W-1:0]      r_cnt;
   logic [DIVIDEND_W-1:0] r_quot;
   logic [DIVISOR_W-1:0]  r_rem;
   logic                  r_dbz;
   logic                  r_in_ready;
   logic                  r_out_valid;

   logic [DIVISOR_W:0]    w_pr_sh;
   logic                  w_ge;
   logic [DIVISOR_W:0]    w_pr_nx;
   logic [DIVIDEND_W-1:0] w_shift_nx;

   // Partial remainder carries one spare bit so the shifted value never overflows before the compare.
   assign w_pr_sh    = {r_pr[DIVISOR_W-1:0], r_shift[DIVIDEND_W-1]};
   assign w_ge       = (w_pr_sh >= {1'b0, r_divisor});
   assign w_pr_nx    = w_ge ? (w_pr_sh - {1'b0, r_divisor}) : w_pr_sh;
   assign w_shift_nx = {r_shift[DIVIDEND_W-2:0], w_ge};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_shift     <= '0;
         r_divisor   <= '0;
         r_pr        <= '0;
         r_cnt       <= '0;
         r_quot      <= '0;
         r_rem       <= '0;
         r_dbz       <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_shift    <= bus.dividend;
                  r_divisor  <= bus.divisor;
                  r_pr       <= '0;
                  r_cnt      <= CNT_LOAD;
                  r_in_ready <= 1'b0;
                  if (bus.divisor == '0) begin
                     r_quot      <= '1;
                     r_rem       <= bus.dividend[DIVISOR_W-1:0];
                     r_dbz       <= 1'b1;
                     r_out_valid <= 1'b1;
                     r_state     <= DONE;
                  end else begin
                     r_dbz   <= 1'b0;
                     r_state <= BUSY;
                  end
               end
            end
            BUSY: begin
               r_pr    <= w_pr_nx;
               r_shift <= w_shift_nx;
               r_cnt   <= r_cnt - 1'b1;
               if (r_cnt == '0) begin
                  r_quot      <= w_shift_nx;
                  r_rem       <= w_pr_nx[DIVISOR_W-1:0];
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready    = r_in_ready;
   assign bus.out_valid   = r_out_valid;
   assign bus.quotient    = r_quot;
   assign bus.remainder   = r_rem;
   assign bus.div_by_zero = r_dbz;
endmodule
